instr_word_encoder: RTL and testbench

- Sequential RV32I instruction encoder and instruction-memory writer. It is the producer side of the core's decode path.
- It accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit RV32I words using the same opcode set the control decoder recognises: R, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
- It writes each word sequentially into instruction memory. It is used by the boot/test loader and by self-check benches to build programs.

---
 rtl/rv_isa_pkg.sv | 39 +++
 rtl/rv_imm_pack.sv | 83 ++++++++
 rtl/instr_word_encoder.sv | 110 +++++++++++
 tb/tb_instr_word_encoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I instruction classes, opcode constants and error codes shared by the
// encoder and the control decoder.
package rv_isa_pkg;

    typedef enum logic [3:0] {
        KIND_R      = 4'd0,
        KIND_OPIMM  = 4'd1,
        KIND_LOAD   = 4'd2,
        KIND_STORE  = 4'd3,
        KIND_BRANCH = 4'd4,
        KIND_LUI    = 4'd5,
        KIND_AUIPC  = 4'd6,
        KIND_JAL    = 4'd7,
        KIND_JALR   = 4'd8
    } kind_t;

    // Class codes are opcode[6:2]; opcode[1:0] is always 2'b11 for 32-bit instructions.
    localparam logic [4:0] OPC_R      = 5'b01100;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_ALIGN   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_ERR} state_t;

    function automatic logic [6:0] opcode7(input logic [4:0] code);
        return {code, 2'b11};
    endfunction

endpackage

// File: rtl/rv_imm_pack.sv
// rv_imm_pack: combinational RV32I field packer with legality, alignment and range checks.
module rv_imm_pack
    import rv_isa_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [1:0]  err_code
);
    logic        fit12, fit13, fit21, shamt_ok, shift, legal, aligned, in_range;
    logic [6:0]  f7_alt;
    logic [4:0]  code;
    logic [24:0] body;

    always_comb begin
        // A signed value fits N bits when all bits above N-1 equal the sign bit.
        fit12    = &imm[31:11] | ~|imm[31:11];
        fit13    = &imm[31:12] | ~|imm[31:12];
        fit21    = &imm[31:20] | ~|imm[31:20];
        shamt_ok = ~|imm[31:5];
        shift    = funct3[1:0] == 2'b01;
        f7_alt   = alt ? 7'b0100000 : 7'b0000000;
        code     = OPC_R;
        body     = '0;
        legal    = 1'b1;
        aligned  = 1'b1;
        in_range = 1'b1;
        case (kind)
            KIND_R: body = {f7_alt, rs2, rs1, funct3, rd};
            KIND_OPIMM: begin
                code     = OPC_OPIMM;
                in_range = shift ? shamt_ok : fit12;
                body     = shift ? {funct3[2] ? f7_alt : 7'b0, imm[4:0], rs1, funct3, rd}
                                 : {imm[11:0], rs1, funct3, rd};
            end
            KIND_LOAD: begin
                code     = OPC_LOAD;
                legal    = funct3 != 3'b011 && funct3[2:1] != 2'b11;
                in_range = fit12;
                body     = {imm[11:0], rs1, funct3, rd};
            end
            KIND_STORE: begin
                code     = OPC_STORE;
                legal    = !funct3[2] && funct3[1:0] != 2'b11;
                in_range = fit12;
                body     = {imm[11:5], rs2, rs1, funct3, imm[4:0]};
            end
            KIND_BRANCH: begin
                code     = OPC_BRANCH;
                legal    = funct3[2:1] != 2'b01;
                aligned  = !imm[0];
                in_range = fit13;
                body     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11]};
            end
            KIND_LUI, KIND_AUIPC: begin
                code    = kind == KIND_LUI ? OPC_LUI : OPC_AUIPC;
                aligned = ~|imm[11:0];
                body    = {imm[31:12], rd};
            end
            KIND_JAL: begin
                code     = OPC_JAL;
                aligned  = !imm[0];
                in_range = fit21;
                body     = {imm[20], imm[10:1], imm[11], imm[19:12], rd};
            end
            KIND_JALR: begin
                code     = OPC_JALR;
                legal    = funct3 == 3'b000;
                in_range = fit12;
                body     = {imm[11:0], rs1, funct3, rd};
            end
            default: legal = 1'b0;
        endcase
        word     = {body, opcode7(code)};
        err_code = !legal ? ERR_ILLEGAL : !aligned ? ERR_ALIGN : !in_range ? ERR_RANGE : ERR_NONE;
    end

endmodule

// File: rtl/instr_word_encoder.sv
// instr_word_encoder: accepts field-level RV32I requests and writes the packed words
// sequentially into instruction memory (IDLE -> ENC -> WR, sticky ERR on illegal input).
module instr_word_encoder
    import rv_isa_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_kind,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [2:0]    in_funct3,
    input  logic          in_alt,
    input  logic [31:0]   in_imm,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err,
    output logic [1:0]    err_code
);
    state_t      state, nxt;
    logic        accept;
    logic [3:0]  r_kind;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [2:0]  r_funct3;
    logic        r_alt;
    logic [31:0] r_imm, enc_word;
    logic [1:0]  enc_err;

    rv_imm_pack u_pack (
        .kind     (r_kind),
        .rd       (r_rd),
        .rs1      (r_rs1),
        .rs2      (r_rs2),
        .funct3   (r_funct3),
        .alt      (r_alt),
        .imm      (r_imm),
        .word     (enc_word),
        .err_code (enc_err)
    );

    assign mem_addr = count[AW-1:0];

    always_ff @(posedge CLK) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (clr) nxt = S_IDLE;
        else case (state)
            S_IDLE:  nxt = accept ? S_ENC : S_IDLE;
            S_ENC:   nxt = enc_err == ERR_NONE ? S_WR : S_ERR;
            S_WR:    nxt = S_IDLE;
            default: nxt = S_ERR;
        endcase
    end

    always_comb begin
        full     = count == (AW+1)'(DEPTH);
        in_ready = state == S_IDLE && !full;
        accept   = in_valid && in_ready && !clr;
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            r_kind   <= in_kind;
            r_rd     <= in_rd;
            r_rs1    <= in_rs1;
            r_rs2    <= in_rs2;
            r_funct3 <= in_funct3;
            r_alt    <= in_alt;
            r_imm    <= in_imm;
        end
    end

    // A clear during WR leaves the already-issued strobe alone but zeroes the count.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (clr) begin
            mem_we   <= 1'b0;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            mem_we <= state == S_ENC && enc_err == ERR_NONE;
            if (state == S_ENC && enc_err == ERR_NONE) mem_wdata <= enc_word;
            if (state == S_ENC && enc_err != ERR_NONE) begin
                err      <= 1'b1;
                err_code <= enc_err;
            end
            if (state == S_WR) count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_word_encoder.sv
// tb_instr_word_encoder: directed vectors checked against an arithmetic RV32I model and a
// write scoreboard; a second DEPTH=4 instance exercises the full boundary.
module tb_instr_word_encoder;
    import rv_isa_pkg::*;

    logic        CLK = 0, RESET_N = 0, clr = 0, in_valid = 0, in_alt = 0;
    logic [3:0]  in_kind = 0;
    logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [2:0]  in_funct3 = 0;
    logic [31:0] in_imm = 0;
    logic        in_ready, mem_we, full, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] count;
    logic [1:0]  err_code;
    logic        valid4 = 0, clr4 = 0, ready4, we4, full4, err4;
    logic [1:0]  addr4, code4;
    logic [31:0] wdata4;
    logic [2:0]  count4;

    int total = 0, bad = 0, exp_n = 0, m_cnt = 0;
    bit started = 0;
    int          qa[$];
    logic [31:0] qd[$];

    instr_word_encoder dut (
        .CLK(CLK), .RESET_N(RESET_N), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .full(full),
        .err(err), .err_code(err_code)
    );

    instr_word_encoder #(.DEPTH(4)) dut4 (
        .CLK(CLK), .RESET_N(RESET_N), .clr(clr4), .in_valid(valid4), .in_ready(ready4),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm), .mem_we(we4),
        .mem_addr(addr4), .mem_wdata(wdata4), .count(count4), .full(full4),
        .err(err4), .err_code(code4)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference encoder written from the ISA field layout using integer arithmetic.
    function automatic void model(input logic [3:0] k, input logic [4:0] rd, rs1, rs2,
                                  input logic [2:0] f3, input logic alt, input logic [31:0] imm,
                                  output logic [31:0] w, output logic [1:0] c);
        int v, d, s1, s2, f, base;
        bit ill, mis, oor;
        v = int'($signed(imm)); d = int'(rd); s1 = int'(rs1); s2 = int'(rs2); f = int'(f3);
        ill = 0; mis = 0; oor = 0; w = 0;
        base = (s1 << 15) | (f << 12) | (d << 7);
        case (k)
            4'd0: w = ((alt ? 32 : 0) << 25) | (s2 << 20) | base | 'h33;
            4'd1: if (f == 1 || f == 5) begin
                      oor = v < 0 || v > 31;
                      w = ((f == 5 && alt) ? 32 << 25 : 0) | ((v & 31) << 20) | base | 'h13;
                  end else begin
                      oor = v < -2048 || v > 2047;
                      w = ((v & 'hfff) << 20) | base | 'h13;
                  end
            4'd2: begin
                ill = f == 3 || f == 6 || f == 7;
                oor = v < -2048 || v > 2047;
                w = ((v & 'hfff) << 20) | base | 'h03;
            end
            4'd3: begin
                ill = f > 2;
                oor = v < -2048 || v > 2047;
                w = (((v >> 5) & 'h7f) << 25) | (s2 << 20) | (s1 << 15) | (f << 12) | ((v & 31) << 7) | 'h23;
            end
            4'd4: begin
                ill = f == 2 || f == 3;
                mis = (v & 1) != 0;
                oor = v < -4096 || v > 4094;
                w = (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3f) << 25) | (s2 << 20) | (s1 << 15)
                  | (f << 12) | (((v >> 1) & 'hf) << 8) | (((v >> 11) & 1) << 7) | 'h63;
            end
            4'd5, 4'd6: begin
                mis = (v & 'hfff) != 0;
                w = (v & 'hfffff000) | (d << 7) | (k == 5 ? 'h37 : 'h17);
            end
            4'd7: begin
                mis = (v & 1) != 0;
                oor = v < -1048576 || v > 1048574;
                w = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3ff) << 21) | (((v >> 11) & 1) << 20)
                  | (((v >> 12) & 'hff) << 12) | (d << 7) | 'h6f;
            end
            4'd8: begin
                ill = f != 0;
                oor = v < -2048 || v > 2047;
                w = ((v & 'hfff) << 20) | base | 'h67;
            end
            default: ill = 1;
        endcase
        c = ill ? 2'b01 : mis ? 2'b11 : oor ? 2'b10 : 2'b00;
    endfunction

    task automatic send(input logic [3:0] k, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                        input logic alt, input logic [31:0] imm, output logic [1:0] c);
        logic [31:0] w;
        int n = 0;
        while (!in_ready && n < 20) begin @(posedge CLK); #1; n++; end
        if (n >= 20) chk("ready_timeout", 32'(in_ready), 1);
        in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_alt = alt; in_imm = imm;
        in_valid = 1;
        @(posedge CLK); #1;
        in_valid = 0;
        model(k, rd, rs1, rs2, f3, alt, imm, w, c);
        if (c == 2'b00) begin
            qa.push_back(exp_n % 1024);
            qd.push_back(w);
            exp_n++;
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic do_clr();
        clr = 1;
        @(posedge CLK); #1;
        clr = 0;
        exp_n = 0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_ready"}, 32'(in_ready), 1);
        chk({p, "_full"}, 32'(full), 0);
        chk({p, "_we"}, 32'(mem_we), 0);
        chk({p, "_addr"}, 32'(mem_addr), 0);
        chk({p, "_wdata"}, mem_wdata, 0);
        chk({p, "_count"}, 32'(count), 0);
        chk({p, "_err"}, 32'(err), 0);
        chk({p, "_code"}, 32'(err_code), 0);
    endtask

    task automatic legal(input logic [3:0] k, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                         input logic alt, input logic [31:0] imm);
        logic [1:0] c;
        send(k, rd, rs1, rs2, f3, alt, imm, c);
        settle();
        chk("legal_err", 32'(err), 0);
        chk("legal_count", 32'(count), 32'(exp_n));
    endtask

    task automatic illegal(input logic [3:0] k, input logic [2:0] f3, input logic [31:0] imm,
                           input logic [1:0] want);
        logic [1:0] c;
        send(k, 5'd1, 5'd2, 5'd3, f3, 1'b0, imm, c);
        chk("model_code", 32'(c), 32'(want));
        settle();
        chk("err_flag", 32'(err), 1);
        chk("err_code", 32'(err_code), 32'(want));
        chk("err_ready", 32'(in_ready), 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("err_sticky", 32'(in_ready), 0);
        do_clr();
        chk("clr_err", 32'(err), 0);
        chk("clr_code", 32'(err_code), 0);
        chk("clr_ready", 32'(in_ready), 1);
    endtask

    // Model count of completed writes, reset by reset/clr like the memory-side view.
    always @(posedge CLK) begin
        if (!RESET_N || clr) m_cnt = 0;
        else if (mem_we) m_cnt++;
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("count", 32'(count), 32'(m_cnt));
            chk("mem_addr", 32'(mem_addr), 32'(m_cnt % 1024));
            chk("full", 32'(full), 32'(m_cnt == 1024));
            if (mem_we) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_we actual=1 required=0 addr=%0d", mem_addr);
                end else begin
                    chk("wr_addr", 32'(mem_addr), 32'(qa.pop_front()));
                    chk("wr_data", mem_wdata, qd.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=done");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [1:0]  c;
        int nw;
        model(KIND_OPIMM, 1, 0, 0, 0, 0, 5, w, c);             chk("pin_addi", w, 32'h00500093);
        model(KIND_R, 3, 1, 2, 0, 0, 0, w, c);                 chk("pin_add", w, 32'h002081B3);
        model(KIND_R, 3, 1, 2, 0, 1, 0, w, c);                 chk("pin_sub", w, 32'h402081B3);
        model(KIND_STORE, 0, 1, 2, 2, 0, 8, w, c);             chk("pin_sw", w, 32'h0020A423);
        model(KIND_BRANCH, 0, 1, 2, 0, 0, -32'sd4, w, c);      chk("pin_beq", w, 32'hFE208EE3);
        model(KIND_JAL, 1, 0, 0, 0, 0, 8, w, c);               chk("pin_jal", w, 32'h008000EF);
        model(KIND_LUI, 5, 0, 0, 0, 0, 32'h12345000, w, c);    chk("pin_lui", w, 32'h123452B7);

        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1;
        chk_reset("rst");
        started = 1;

        legal(KIND_OPIMM, 1, 0, 0, 0, 0, 5);
        chk("addi_word", mem_wdata, 32'h00500093);
        do_clr();
        legal(KIND_R, 3, 1, 2, 0, 0, 0);
        chk("add_word", mem_wdata, 32'h002081B3);
        legal(KIND_R, 3, 1, 2, 0, 1, 0);
        chk("sub_word", mem_wdata, 32'h402081B3);
        legal(KIND_STORE, 0, 1, 2, 2, 0, 8);
        chk("sw_word", mem_wdata, 32'h0020A423);
        legal(KIND_BRANCH, 0, 1, 2, 0, 0, -32'sd4);
        chk("beq_word", mem_wdata, 32'hFE208EE3);
        legal(KIND_JAL, 1, 0, 0, 0, 0, 8);
        chk("jal_word", mem_wdata, 32'h008000EF);
        legal(KIND_LUI, 5, 0, 0, 0, 0, 32'h12345000);
        chk("lui_word", mem_wdata, 32'h123452B7);
        legal(KIND_LOAD, 4, 3, 0, 2, 0, -32'sd12);
        legal(KIND_JALR, 0, 1, 9, 0, 0, 32'd2047);
        legal(KIND_AUIPC, 7, 0, 0, 0, 0, 32'hFFFFF000);
        legal(KIND_OPIMM, 2, 3, 0, 1, 1, 31);
        legal(KIND_OPIMM, 2, 3, 0, 5, 1, 7);
        legal(KIND_OPIMM, 6, 6, 0, 0, 0, -32'sd2048);
        legal(KIND_BRANCH, 0, 4, 5, 7, 0, 4094);
        legal(KIND_BRANCH, 0, 4, 5, 1, 0, -32'sd4096);
        legal(KIND_JAL, 0, 0, 0, 0, 0, -32'sd1048576);
        legal(KIND_LOAD, 8, 9, 0, 5, 0, 0);

        illegal(KIND_BRANCH, 0, 3, 2'b11);
        illegal(4'd12, 0, 0, 2'b01);
        illegal(KIND_OPIMM, 0, 4096, 2'b10);
        illegal(KIND_BRANCH, 2, 8, 2'b01);
        illegal(KIND_JALR, 1, 0, 2'b01);
        illegal(KIND_LUI, 0, 32'h00000800, 2'b11);
        illegal(KIND_OPIMM, 1, 32, 2'b10);
        illegal(KIND_BRANCH, 0, 4096, 2'b10);
        illegal(KIND_BRANCH, 0, 4097, 2'b11);
        illegal(KIND_LOAD, 3, 5000, 2'b01);
        illegal(KIND_STORE, 0, -32'sd2049, 2'b10);

        // clr and handshake in the same cycle: the request is dropped
        legal(KIND_OPIMM, 1, 0, 0, 0, 0, 1);
        in_valid = 1; clr = 1;
        @(posedge CLK); #1;
        in_valid = 0; clr = 0; exp_n = 0;
        settle();
        chk("clr_drop_count", 32'(count), 0);
        chk("clr_drop_ready", 32'(in_ready), 1);

        // reset while in WR
        legal(KIND_OPIMM, 1, 0, 0, 0, 0, 2);
        send(KIND_OPIMM, 1, 0, 0, 0, 0, 3, c);
        @(posedge CLK); #1;
        chk("wr_strobe_rst", 32'(mem_we), 1);
        RESET_N = 0;
        @(posedge CLK); #1;
        chk_reset("rst_wr");
        RESET_N = 1;
        exp_n = 0;

        // clr while in WR: strobe already issued, count returns to zero
        legal(KIND_R, 3, 1, 2, 0, 0, 0);
        send(KIND_R, 4, 1, 2, 0, 0, 0, c);
        @(posedge CLK); #1;
        chk("wr_strobe_clr", 32'(mem_we), 1);
        clr = 1;
        @(posedge CLK); #1;
        clr = 0; exp_n = 0;
        chk("clr_wr_count", 32'(count), 0);
        chk("clr_wr_we", 32'(mem_we), 0);
        chk("clr_wr_ready", 32'(in_ready), 1);

        // DEPTH=4 instance: continuous requests must stop after four writes
        in_kind = KIND_OPIMM; in_rd = 1; in_rs1 = 0; in_rs2 = 0; in_funct3 = 0; in_alt = 0; in_imm = 5;
        chk("d4_ready0", 32'(ready4), 1);
        valid4 = 1;
        nw = 0;
        repeat (30) begin
            @(negedge CLK);
            if (we4) begin
                chk("d4_addr", 32'(addr4), 32'(nw));
                chk("d4_data", wdata4, 32'h00500093);
                nw++;
            end
        end
        chk("d4_writes", 32'(nw), 4);
        chk("d4_count", 32'(count4), 4);
        chk("d4_full", 32'(full4), 1);
        chk("d4_ready", 32'(ready4), 0);
        chk("d4_err", 32'(err4), 0);
        chk("d4_code", 32'(code4), 0);
        valid4 = 0;
        @(posedge CLK); #1;
        clr4 = 1;
        @(posedge CLK); #1;
        clr4 = 0;
        chk("d4_clr_count", 32'(count4), 0);
        chk("d4_clr_full", 32'(full4), 0);
        chk("d4_clr_ready", 32'(ready4), 1);

        repeat (3) @(posedge CLK);
        #1;
        chk("queue_empty", 32'(qa.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
